// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the burst-memory responder
package rv32i_types;

  localparam int BMEM_BEATS      = 4;
  localparam int BMEM_LINE_BYTES = 32;
  localparam int BMEM_BEAT_W     = 64;
  localparam int BMEM_LINE_W     = BMEM_BEATS * BMEM_BEAT_W;

  typedef struct packed {
    logic [26:0] line_addr;
    logic [5:0]  stamp;
  } bmem_rd_req_t;

  typedef enum logic {w_idle, w_beat}  bmem_wstate_e;
  typedef enum logic {r_idle, r_burst} bmem_rstate_e;

  // Age of a request in cycles; mod-64 wrap is intended.
  function automatic logic [5:0] stamp_age(input logic [5:0] now, input logic [5:0] stamp);
    return now - stamp;
  endfunction

endpackage

// File: rtl/queue.sv
// rtl/queue.sv - synchronous FIFO exposing its head entry and occupancy
module queue #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/bmem_responder.sv
// rtl/bmem_responder.sv - line-organized burst-memory responder for the CPU bmem port
// Reads are queued with an arrival stamp and replayed as 4-beat bursts after READ_LATENCY.
module bmem_responder
  import rv32i_types::*;
#(
  parameter int LINE_IDX_BITS = 8,
  parameter int READ_LATENCY  = 6,
  parameter int RQ_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        protocol_err
);

  localparam int LINES = 1 << LINE_IDX_BITS;
  localparam int QAW   = $clog2(RQ_DEPTH);

  logic [BMEM_LINE_W-1:0] store [LINES];

  logic [5:0]               cnt_q;
  logic                     ready_q, ready_d, err_q;
  bmem_wstate_e             w_state_q;
  logic [1:0]               w_cnt_q;
  logic [LINE_IDX_BITS-1:0] w_idx_q;
  logic [63:0]              w_beat_q [3];
  bmem_rstate_e             r_state_q;
  logic [1:0]               r_beat_q;
  logic [191:0]             r_buf_q;
  logic [26:0]              r_addr_q;
  logic                     rvalid_q;
  logic [63:0]              rdata_q;

  bmem_rd_req_t             rq_push, rq_head;
  logic                     q_empty, q_full_unused;
  logic [QAW:0]             q_count, q_count_nxt;

  logic rd_acc, wr_acc, w_busy, illegal, w_abort, commit, head_ripe, burst_last, start;
  logic [BMEM_LINE_W-1:0]   commit_line, start_line;
  logic [LINE_IDX_BITS-1:0] head_idx;
  logic                     addr_lo_unused;

  assign addr_lo_unused = ^bmem_addr[4:0];

  assign w_busy  = (w_state_q == w_beat);
  assign rd_acc  = bmem_read && ready_q && !bmem_write;
  assign wr_acc  = bmem_write && ready_q && !bmem_read;
  // A write while not ready is only legal as the continuation of an accepted burst.
  assign illegal = (bmem_read && bmem_write) || (bmem_read && (!ready_q || w_busy)) ||
                   (bmem_write && !ready_q && !w_busy);
  assign w_abort = w_busy && !bmem_write;
  assign commit  = w_busy && bmem_write && (w_cnt_q == 2'd3);
  assign commit_line = {bmem_wdata, w_beat_q[2], w_beat_q[1], w_beat_q[0]};

  assign rq_push    = '{line_addr: bmem_addr[31:5], stamp: cnt_q};
  assign head_idx   = rq_head.line_addr[LINE_IDX_BITS-1:0];
  assign head_ripe  = !q_empty && (stamp_age(cnt_q, rq_head.stamp) >= 6'(READ_LATENCY - 1));
  assign burst_last = (r_state_q == r_burst) && (r_beat_q == 2'd3);
  assign start      = head_ripe && ((r_state_q == r_idle) || burst_last);
  // Forward a line committing this very cycle so the burst sees the newest data.
  assign start_line = (commit && (w_idx_q == head_idx)) ? commit_line : store[head_idx];

  assign q_count_nxt = q_count + (QAW+1)'(rd_acc) - (QAW+1)'(start);
  assign ready_d     = (q_count_nxt != (QAW+1)'(RQ_DEPTH)) && !w_busy && !wr_acc;

  queue #(.WIDTH($bits(bmem_rd_req_t)), .DEPTH(RQ_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_acc),
    .push_data (rq_push),
    .pop       (start),
    .head      (rq_head),
    .empty     (q_empty),
    .full      (q_full_unused),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      w_state_q <= w_idle;
      w_cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + 6'd1;
      ready_q <= ready_d;
      if (illegal || w_abort) err_q <= 1'b1;
      case (w_state_q)
        w_idle: if (wr_acc) begin
          w_state_q   <= w_beat;
          w_cnt_q     <= 2'd1;
          w_idx_q     <= bmem_addr[LINE_IDX_BITS+4:5];
          w_beat_q[0] <= bmem_wdata;
        end
        w_beat: begin
          if (!bmem_write || w_cnt_q == 2'd3) begin
            w_state_q <= w_idle;
          end else begin
            w_beat_q[w_cnt_q] <= bmem_wdata;
            w_cnt_q           <= w_cnt_q + 2'd1;
          end
        end
        default: w_state_q <= w_idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit) store[w_idx_q] <= commit_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= r_idle;
      r_beat_q  <= '0;
      r_addr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (start) begin
      r_state_q <= r_burst;
      r_beat_q  <= '0;
      r_buf_q   <= start_line[255:64];
      r_addr_q  <= rq_head.line_addr;
      rvalid_q  <= 1'b1;
      rdata_q   <= start_line[63:0];
    end else if (burst_last) begin
      r_state_q <= r_idle;
      rvalid_q  <= 1'b0;
    end else if (r_state_q == r_burst) begin
      r_beat_q <= r_beat_q + 2'd1;
      rdata_q  <= r_buf_q[63:0];
      r_buf_q  <= {64'd0, r_buf_q[191:64]};
    end
  end

  assign bmem_ready   = ready_q;
  assign bmem_raddr   = {r_addr_q, 5'd0};
  assign bmem_rdata   = rdata_q;
  assign bmem_rvalid  = rvalid_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_bmem_responder.sv
// tb/tb_bmem_responder.sv - randomized bench for bmem_responder against a cycle-scheduled line model
module tb_bmem_responder;

  localparam int L  = 6;
  localparam int D  = 4;
  localparam int IB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        protocol_err;

  always #5 clk = ~clk;

  bmem_responder #(.LINE_IDX_BITS(IB), .READ_LATENCY(L), .RQ_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_ready   (bmem_ready),
    .bmem_raddr   (bmem_raddr),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid),
    .protocol_err (protocol_err)
  );

  typedef struct {
    logic [26:0]  la;
    int           first;
    logic [255:0] data;
  } burst_t;

  burst_t       exp_q[$];
  logic [255:0] mem_m [256];
  int           cyc = 0, last_first = -100, pend = 0, n_checks = 0, n_fail = 0;
  bit           rdy_m = 0, err_m = 0, w_act = 0;
  int           w_n = 0;
  logic [7:0]   w_idx;
  logic [63:0]  w_b [4];
  logic [7:0]   pool [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd16, 8'd64};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare outputs.
  task automatic step(input bit r_in, input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] wd);
    bit     rdy_n, wbeat, racc, wacc;
    int     f, k;
    burst_t nb;
    rst = r_in; bmem_read = rd; bmem_write = wr; bmem_addr = a; bmem_wdata = wd;
    rdy_n = 0;
    if (r_in) begin
      exp_q.delete(); pend = 0; w_act = 0; last_first = -100; err_m = 0;
    end else begin
      wbeat = w_act;
      if (rd && wr) err_m = 1;
      if ((rd || wr) && !rdy_m && !(wr && wbeat)) err_m = 1;
      if (rd && wbeat) err_m = 1;
      racc = rd && rdy_m && !wr;
      wacc = wr && rdy_m && !rd;
      if (wbeat) begin
        if (!wr) begin
          err_m = 1; w_act = 0;
        end else begin
          w_b[w_n] = wd; w_n++;
          if (w_n == 4) begin
            mem_m[w_idx] = {w_b[3], w_b[2], w_b[1], w_b[0]};
            w_act = 0;
          end
        end
      end
      if (wacc) begin
        w_act = 1; w_n = 1; w_idx = a[12:5]; w_b[0] = wd;
      end
      if (racc) begin
        f = (cyc + L > last_first + 4) ? cyc + L : last_first + 4;
        nb.la = a[31:5]; nb.first = f; nb.data = '0;
        exp_q.push_back(nb);
        last_first = f; pend++;
      end
      foreach (exp_q[i]) if (exp_q[i].first - 1 == cyc) begin
        exp_q[i].data = mem_m[exp_q[i].la[7:0]];
        pend--;
      end
      rdy_n = (pend != D) && !wacc && !wbeat;
    end
    @(posedge clk); #1;
    cyc++; rdy_m = rdy_n;
    check("ready", bmem_ready, rdy_m);
    check("protocol_err", protocol_err, err_m);
    if (exp_q.size() > 0 && cyc >= exp_q[0].first) begin
      k = cyc - exp_q[0].first;
      check("rvalid", bmem_rvalid, 1'b1);
      check("raddr", bmem_raddr, {exp_q[0].la, 5'd0});
      check("rdata", bmem_rdata, exp_q[0].data[64*k +: 64]);
      if (k >= 3) void'(exp_q.pop_front());
    end else begin
      check("rvalid_idle", bmem_rvalid, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 32'h0, 64'h0);
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!rdy_m && t < 60) begin idle(1); t++; end
    if (!rdy_m) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || !rdy_m) && t < 300) begin idle(1); t++; end
    if (exp_q.size() > 0) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3);
    wait_rdy();
    step(0, 0, 1, a, b0); step(0, 0, 1, a, b1); step(0, 0, 1, a, b2); step(0, 0, 1, a, b3);
  endtask

  task automatic rd_line(input logic [31:0] a);
    wait_rdy();
    step(0, 1, 0, a, 64'h0);
  endtask

  function automatic logic [31:0] rand_addr(input logic [7:0] idx);
    logic [31:0] r;
    r = $urandom();
    return {r[31:13], idx, r[4:0]};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int wleft, sel, f, t;
    logic [31:0] wa;
    logic [63:0] nb0;
    repeat (3) step(1, 0, 0, 32'h0, 64'h0);
    check("rst_raddr", bmem_raddr, 32'h0);
    check("rst_rdata", bmem_rdata, 64'h0);
    step(0, 0, 0, 32'h0, 64'h0);
    check("ready_after_rst", bmem_ready, 1'b1);

    for (int j = 0; j < 8; j++) wr_line(rand_addr(pool[j]), r64(), r64(), r64(), r64());
    wr_line(32'h100, {8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}});
    drain();

    rd_line(32'h100);
    idle(L - 1);
    check("lat_first_beat", bmem_rvalid, 1'b1);
    check("lat_beat0", bmem_rdata, {8{8'h11}});
    drain();
    rd_line(32'h107);
    idle(L - 1);
    check("misalign_raddr", bmem_raddr, 32'h100);
    check("misalign_beat0", bmem_rdata, {8{8'h11}});
    drain();

    for (int j = 0; j < 5; j++) begin
      rd_line(32'(j * 32));
      if (j == 3) check("full_ready_low", bmem_ready, 1'b0);
    end
    drain();

    rd_line(32'h200);
    idle(1);
    nb0 = r64();
    wr_line(32'h200, nb0, r64(), r64(), r64());
    check("fwd_beat0", bmem_rdata, nb0);
    drain();

    wait_rdy();
    step(0, 1, 1, 32'h40, 64'h0);
    check("err_rd_wr", protocol_err, 1'b1);
    drain();
    step(1, 0, 0, 32'h0, 64'h0);
    step(0, 0, 0, 32'h0, 64'h0);

    wleft = 0; wa = '0;
    repeat (600) begin
      if (wleft > 0) begin
        step(0, 0, 1, wa, r64()); wleft--;
      end else if (rdy_m) begin
        sel = $urandom_range(0, 9);
        if (sel < 4) step(0, 1, 0, rand_addr(pool[$urandom_range(0, 7)]), 64'h0);
        else if (sel < 5) begin
          wa = rand_addr(pool[$urandom_range(0, 7)]);
          step(0, 0, 1, wa, r64()); wleft = 3;
        end else idle(1);
      end else idle(1);
    end
    drain();

    wait_rdy();
    step(0, 0, 1, 32'h100, r64());
    step(0, 0, 1, 32'h100, r64());
    step(0, 0, 0, 32'h100, 64'h0);
    check("err_drop", protocol_err, 1'b1);
    rd_line(32'h100);
    drain();
    check("err_sticky", protocol_err, 1'b1);

    rd_line(32'h40);
    f = exp_q[0].first;
    t = 0;
    while (cyc < f + 1 && t < 50) begin idle(1); t++; end
    check("pre_rst_rvalid", bmem_rvalid, 1'b1);
    step(1, 0, 0, 32'h0, 64'h0);
    check("midburst_rvalid", bmem_rvalid, 1'b0);
    check("midburst_ready", bmem_ready, 1'b0);
    step(0, 0, 0, 32'h0, 64'h0);
    check("post_rst_ready", bmem_ready, 1'b1);
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bmem_responder.md
Name: bmem_responder

Overview:
- Synthesizable responder for the 64-bit burst-memory (bmem) interface the CPU core drives.
- Accepts line reads and line writes, each moving one 32-byte line as 4 beats of 64 bits.
- Returns read bursts in order after a programmable latency, from an internal line-organized store.
- Used in place of the simulation memory model for FPGA/emulation bring-up and as a self-checking bench partner for the CPU's fetch/deserializer path.

Parameters:
- LINE_IDX_BITS, 8, log2 of lines stored; address bits [LINE_IDX_BITS+4:5] index the store, higher bits alias.
- READ_LATENCY, 6, minimum cycles from read acceptance to first rvalid beat; legal range 2..63.
- RQ_DEPTH, 4, outstanding read requests held; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- bmem_addr  input  32  request byte address; bits [4:0] ignored
- bmem_read  input  1  read request, single-cycle pulse
- bmem_write  input  1  write request, held high for 4 consecutive beats
- bmem_wdata  input  64  write beat data, beat 0 in request cycle
- bmem_ready  output  1  responder can accept a new request this cycle
- bmem_raddr  output  32  line address of current read beat, {addr[31:5],5'b0}
- bmem_rdata  output  64  read beat data
- bmem_rvalid  output  1  read beat valid
- protocol_err  output  1  sticky protocol violation flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - bmem_ready=0 during rst, and 1 in the first cycle after rst deasserts.
  - bmem_rvalid=0, bmem_raddr=0, bmem_rdata=0, protocol_err=0.
  - Read FIFO empty, both FSMs idle, cycle counter=0.
  - Store contents are not reset.
- Reset mid-burst: any in-flight read or write is abandoned. A partial write never reaches the store.
- bmem_ready is registered. Deasserted next cycle when any of these holds:
  - read FIFO will hold RQ_DEPTH entries;
  - write FSM is in WBEAT;
  - a write is accepted this cycle.
- Read accept: bmem_read && bmem_ready && !bmem_write.
  - Push {addr[31:5], stamp}; stamp = free-running 6-bit cycle counter.
- Write accept: bmem_write && bmem_ready && !bmem_read.
  - Latch addr[31:5] and wdata into beat 0.
  - Write FSM IDLE->WBEAT with beat count=1.
- Write FSM WBEAT:
  - Each cycle with bmem_write=1, capture wdata into beat[count] and increment count.
  - On count==3 capture, commit the full 256-bit line to store[idx] and return to IDLE.
  - If bmem_write=0 during WBEAT: set protocol_err, discard partial line, return to IDLE.
- Illegal inputs (each sets protocol_err; nothing is accepted):
  - bmem_read && bmem_write together.
  - Any request while bmem_ready=0.
  - bmem_read during WBEAT.
  - Exception: bmem_write during WBEAT is the expected beat stream, not an error.
- Read FSM states RIDLE, RBURST(beat 0..3):
  - RIDLE->RBURST when FIFO non-empty and (counter - head.stamp) mod 64 >= READ_LATENCY-1.
  - On that transition, pop head, load 256-bit line into shift buffer, present beat 0 next cycle.
  - First rvalid appears exactly READ_LATENCY cycles after acceptance when the responder is otherwise idle.
- RBURST:
  - bmem_rvalid=1 for 4 consecutive cycles; beat k = line[64k+:64]; bmem_raddr constant across the burst.
  - After beat 3, return to RIDLE or start the next eligible burst back-to-back with no gap.
- Ordering and visibility:
  - Read bursts are strictly in acceptance order.
  - The line is sampled at burst start, not at acceptance.
  - A write committing in the same cycle as burst start is forwarded, so the read sees the new data.
- Read FIFO full: bmem_ready stays low until a pop. A pop and a push in the same cycle are legal at full-1.
- Reads and writes proceed concurrently: read bursts continue while a write burst streams in.
- Counter wrap: mod-64 difference arithmetic. READ_LATENCY<=63 guarantees no ambiguity.

Decomposition:
- Shared package rv32i_types gains:
  - BMEM_BEATS=4, BMEM_LINE_BYTES=32, BMEM_BEAT_W=64;
  - bmem_rd_req_t {logic [26:0] line_addr; logic [5:0] stamp};
  - enums for write FSM (w_idle, w_beat) and read FSM (r_idle, r_burst).
- Sub-module: reuse the existing queue module as the read request FIFO, WIDTH=$bits(bmem_rd_req_t), DEPTH=RQ_DEPTH.
- Store, write FSM and read FSM stay in bmem_responder.

Test Plan:
- Write burst addr 0x100, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; then read 0x100 -> 4 rvalid beats in that order, raddr=0x100, first beat exactly 6 cycles after the read pulse.
- Read addr 0x107 (misaligned) -> raddr=0x100, same data as above; no protocol_err.
- 5 reads to lines 0x000,0x020,0x040,0x060,0x080 issued whenever ready -> ready low after the 4th until the first pop; 20 contiguous rvalid beats in order; no bubbles between bursts.
- Read of line 0x200 accepted, then write to 0x200 committing at the burst-start cycle -> read returns the new write data (forwarding).
- bmem_write dropped after 2 beats -> protocol_err=1 stays set; a later read of that line returns the old contents.
- rst asserted during RBURST beat 1 -> next cycle rvalid=0, ready=0; after release ready=1, FIFO empty, no further beats.
